// File: rtl/alu_rs.sv
// Collapsing-queue reservation station for an ALU: oldest-first issue into a
// single output register, with tag-broadcast wakeup on stored and inserted operands.
module alu_rs #(
  parameter int DEPTH   = 16,
  parameter int NUM_IN  = 4,
  parameter int NUM_FWD = 4,
  parameter int OP_W    = 5,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_FWD-1:0]          fwd_valid,
  input  logic [NUM_FWD*TAG_W-1:0]    fwd_tag,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_value,
  input  logic [NUM_IN-1:0]           in_valid,
  input  logic [NUM_IN*OP_W-1:0]      in_op,
  input  logic [NUM_IN*TAG_W-1:0]     in_rob,
  input  logic [NUM_IN*TAG_W-1:0]     in_tag_a,
  input  logic [NUM_IN*TAG_W-1:0]     in_tag_b,
  input  logic [NUM_IN*DATA_W-1:0]    in_val_a,
  input  logic [NUM_IN*DATA_W-1:0]    in_val_b,
  input  logic [NUM_IN-1:0]           in_rdy_a,
  input  logic [NUM_IN-1:0]           in_rdy_b,
  output logic                        in_ready,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        out_valid,
  output logic [OP_W-1:0]             out_op,
  output logic [TAG_W-1:0]            out_rob,
  output logic [DATA_W-1:0]           out_val_a,
  output logic [DATA_W-1:0]           out_val_b,
  input  logic                        out_accept
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  rob;
    logic [TAG_W-1:0]  tag_a;
    logic [TAG_W-1:0]  tag_b;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic              rdy_a;
    logic              rdy_b;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  entry_t            wk    [DEPTH];
  logic [CW-1:0]     count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [OP_W-1:0]   out_op_q, out_op_d;
  logic [TAG_W-1:0]  out_rob_q, out_rob_d;
  logic [DATA_W-1:0] out_val_a_q, out_val_a_d;
  logic [DATA_W-1:0] out_val_b_q, out_val_b_d;
  logic              in_ready_c;
  logic              issue_found;
  logic              issue;
  int                issue_idx;
  int                cnt_i;

  // Descending scan so the lowest-numbered matching bus is the one kept.
  function automatic entry_t wake(input entry_t e);
    entry_t r;
    r = e;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (!e.rdy_a && fwd_valid[k] && fwd_tag[k*TAG_W +: TAG_W] == e.tag_a) begin
        r.rdy_a = 1'b1;
        r.val_a = fwd_value[k*DATA_W +: DATA_W];
      end
      if (!e.rdy_b && fwd_valid[k] && fwd_tag[k*TAG_W +: TAG_W] == e.tag_b) begin
        r.rdy_b = 1'b1;
        r.val_b = fwd_value[k*DATA_W +: DATA_W];
      end
    end
    return r;
  endfunction

  function automatic entry_t lane_entry(input int j);
    entry_t r;
    r.op    = in_op[j*OP_W +: OP_W];
    r.rob   = in_rob[j*TAG_W +: TAG_W];
    r.tag_a = in_tag_a[j*TAG_W +: TAG_W];
    r.tag_b = in_tag_b[j*TAG_W +: TAG_W];
    r.val_a = in_val_a[j*DATA_W +: DATA_W];
    r.val_b = in_val_b[j*DATA_W +: DATA_W];
    r.rdy_a = in_rdy_a[j];
    r.rdy_b = in_rdy_b[j];
    return r;
  endfunction

  assign cnt_i      = int'(count_q);
  assign in_ready_c = (cnt_i <= DEPTH - NUM_IN);

  // Issue eligibility looks only at registered readiness; wakeups count next cycle.
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = 0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i < cnt_i && ent_q[i].rdy_a && ent_q[i].rdy_b) begin
        issue_found = 1'b1;
        issue_idx   = i;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      wk[i] = wake(ent_q[i]);
    end
  end

  assign issue = issue_found && (!out_valid_q || out_accept);

  always_comb begin
    int tail;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = wk[i];
    end
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_rob_d   = out_rob_q;
    out_val_a_d = out_val_a_q;
    out_val_b_d = out_val_b_q;

    // Compact over the issued slot first; woken values travel with the shift.
    if (issue) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= issue_idx) ent_d[i] = wk[i+1];
      end
    end
    tail = cnt_i - (issue ? 1 : 0);

    if (in_ready_c) begin
      for (int j = 0; j < NUM_IN; j++) begin
        if (in_valid[j]) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (i == tail) ent_d[i] = wake(lane_entry(j));
          end
          tail = tail + 1;
        end
      end
    end
    count_d = CW'(tail);

    if (issue) begin
      out_valid_d = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (i == issue_idx) begin
          out_op_d    = ent_q[i].op;
          out_rob_d   = ent_q[i].rob;
          out_val_a_d = ent_q[i].val_a;
          out_val_b_d = ent_q[i].val_b;
        end
      end
    end else if (out_accept) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      count_d     = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_rob_q   <= '0;
      out_val_a_q <= '0;
      out_val_b_q <= '0;
    end else begin
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_rob_q   <= out_rob_d;
      out_val_a_q <= out_val_a_d;
      out_val_b_q <= out_val_b_d;
    end
    ent_q <= ent_d;
  end

  assign in_ready  = in_ready_c;
  assign count     = count_q;
  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_rob   = out_rob_q;
  assign out_val_a = out_val_a_q;
  assign out_val_b = out_val_b_q;
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: stimulus pushes expected issues into a queue,
// a negedge monitor pops and compares every consumed output.
module tb_alu_rs;
  localparam int DEPTH   = 16;
  localparam int NUM_IN  = 4;
  localparam int NUM_FWD = 4;
  localparam int OP_W    = 5;
  localparam int TAG_W   = 6;
  localparam int DATA_W  = 16;
  localparam int EW      = OP_W + TAG_W + 2 * DATA_W;

  logic                      clk;
  logic                      reset;
  logic                      flush;
  logic [NUM_FWD-1:0]        fwd_valid;
  logic [NUM_FWD*TAG_W-1:0]  fwd_tag;
  logic [NUM_FWD*DATA_W-1:0] fwd_value;
  logic [NUM_IN-1:0]         in_valid;
  logic [NUM_IN*OP_W-1:0]    in_op;
  logic [NUM_IN*TAG_W-1:0]   in_rob;
  logic [NUM_IN*TAG_W-1:0]   in_tag_a;
  logic [NUM_IN*TAG_W-1:0]   in_tag_b;
  logic [NUM_IN*DATA_W-1:0]  in_val_a;
  logic [NUM_IN*DATA_W-1:0]  in_val_b;
  logic [NUM_IN-1:0]         in_rdy_a;
  logic [NUM_IN-1:0]         in_rdy_b;
  logic                      in_ready;
  logic [$clog2(DEPTH):0]    count;
  logic                      out_valid;
  logic [OP_W-1:0]           out_op;
  logic [TAG_W-1:0]          out_rob;
  logic [DATA_W-1:0]         out_val_a;
  logic [DATA_W-1:0]         out_val_b;
  logic                      out_accept;

  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];

  alu_rs #(
    .DEPTH(DEPTH), .NUM_IN(NUM_IN), .NUM_FWD(NUM_FWD),
    .OP_W(OP_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fwd_valid(fwd_valid), .fwd_tag(fwd_tag), .fwd_value(fwd_value),
    .in_valid(in_valid), .in_op(in_op), .in_rob(in_rob),
    .in_tag_a(in_tag_a), .in_tag_b(in_tag_b),
    .in_val_a(in_val_a), .in_val_b(in_val_b),
    .in_rdy_a(in_rdy_a), .in_rdy_b(in_rdy_b),
    .in_ready(in_ready), .count(count),
    .out_valid(out_valid), .out_op(out_op), .out_rob(out_rob),
    .out_val_a(out_val_a), .out_val_b(out_val_b),
    .out_accept(out_accept)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush     = 1'b0;
    fwd_valid = '0;
    fwd_tag   = '0;
    fwd_value = '0;
    in_valid  = '0;
    in_op     = '0;
    in_rob    = '0;
    in_tag_a  = '0;
    in_tag_b  = '0;
    in_val_a  = '0;
    in_val_b  = '0;
    in_rdy_a  = '0;
    in_rdy_b  = '0;
  endtask

  task automatic set_lane(input int j, input logic [OP_W-1:0] op, input logic [TAG_W-1:0] rob,
                          input logic [TAG_W-1:0] ta, input logic ra, input logic [DATA_W-1:0] va,
                          input logic [TAG_W-1:0] tb, input logic rb, input logic [DATA_W-1:0] vb);
    in_valid[j]                 = 1'b1;
    in_op[j*OP_W +: OP_W]       = op;
    in_rob[j*TAG_W +: TAG_W]    = rob;
    in_tag_a[j*TAG_W +: TAG_W]  = ta;
    in_rdy_a[j]                 = ra;
    in_val_a[j*DATA_W +: DATA_W] = va;
    in_tag_b[j*TAG_W +: TAG_W]  = tb;
    in_rdy_b[j]                 = rb;
    in_val_b[j*DATA_W +: DATA_W] = vb;
  endtask

  task automatic set_fwd(input int k, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val);
    fwd_valid[k]                  = 1'b1;
    fwd_tag[k*TAG_W +: TAG_W]     = tag;
    fwd_value[k*DATA_W +: DATA_W] = val;
  endtask

  task automatic push_exp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] rob,
                          input logic [DATA_W-1:0] va, input logic [DATA_W-1:0] vb);
    exp_q.push_back({op, rob, va, vb});
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    tick();
    tick();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && out_valid && out_accept) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got rob %0h expected none", out_rob);
      end else begin
        check("out_txn", 64'({out_op, out_rob, out_val_a, out_val_b}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset      = 1'b1;
    out_accept = 1'b1;
    clear_inputs();
    repeat (3) tick();
    reset = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_fields", 64'({out_op, out_rob, out_val_a, out_val_b}), 64'd0);

    // ready insert, minimum latency
    set_lane(0, 5'd3, 6'd5, 6'd0, 1'b1, 16'h0010, 6'd0, 1'b1, 16'h0020);
    push_exp(5'd3, 6'd5, 16'h0010, 16'h0020);
    tick();
    clear_inputs();
    check("ri_count_n1", 64'(count), 64'd1);
    check("ri_outv_n1", 64'(out_valid), 64'd0);
    tick();
    check("ri_outv_n2", 64'(out_valid), 64'd1);
    check("ri_rob_n2", 64'(out_rob), 64'd5);
    check("ri_count_n2", 64'(count), 64'd0);
    wait_drain(10);

    // same-cycle wakeup, then lowest bus wins
    set_lane(0, 5'd1, 6'd7, 6'd9, 1'b0, 16'h0000, 6'd0, 1'b1, 16'h1111);
    set_fwd(2, 6'd9, 16'hBEEF);
    push_exp(5'd1, 6'd7, 16'hBEEF, 16'h1111);
    tick();
    clear_inputs();
    set_lane(0, 5'd2, 6'd8, 6'd9, 1'b0, 16'h0000, 6'd0, 1'b1, 16'h2222);
    set_fwd(1, 6'd9, 16'h1234);
    set_fwd(2, 6'd9, 16'hBEEF);
    set_fwd(3, 6'd9, 16'h5555);
    push_exp(5'd2, 6'd8, 16'h1234, 16'h2222);
    tick();
    clear_inputs();
    wait_drain(10);

    // oldest-first with compaction and wake during shift
    for (int j = 0; j < 4; j++)
      set_lane(j, 5'd0, 6'(j + 1), 6'(11 + j), 1'b0, 16'h0000, 6'd0, 1'b1, 16'(16'h00B0 + j));
    push_exp(5'd0, 6'd3, 16'h0333, 16'h00B2);
    push_exp(5'd0, 6'd1, 16'h0111, 16'h00B0);
    push_exp(5'd0, 6'd2, 16'h0222, 16'h00B1);
    push_exp(5'd0, 6'd4, 16'h0444, 16'h00B3);
    tick();
    clear_inputs();
    check("ord_count4", 64'(count), 64'd4);
    set_fwd(0, 6'd13, 16'h0333);
    tick();
    clear_inputs();
    check("ord_no_early_issue", 64'(out_valid), 64'd0);
    set_fwd(0, 6'd11, 16'h0111);
    set_fwd(1, 6'd14, 16'h0444);
    tick();
    clear_inputs();
    check("ord_first_rob", 64'(out_rob), 64'd3);
    check("ord_count3", 64'(count), 64'd3);
    set_fwd(0, 6'd12, 16'h0222);
    tick();
    clear_inputs();
    check("ord_second_rob", 64'(out_rob), 64'd1);
    check("ord_count2", 64'(count), 64'd2);
    wait_drain(10);

    // backpressure then back-to-back release
    out_accept = 1'b0;
    for (int j = 0; j < 3; j++) begin
      set_lane(j, 5'(4 + j), 6'(20 + j), 6'd0, 1'b1, 16'(16'h0A00 + j), 6'd0, 1'b1, 16'(16'h0B00 + j));
      push_exp(5'(4 + j), 6'(20 + j), 16'(16'h0A00 + j), 16'(16'h0B00 + j));
    end
    tick();
    clear_inputs();
    tick();
    for (int n = 0; n < 3; n++) begin
      tick();
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_rob", 64'(out_rob), 64'd20);
      check("bp_hold_count", 64'(count), 64'd2);
    end
    out_accept = 1'b1;
    check("bp_rel_c0", 64'({out_valid, out_rob}), 64'({1'b1, 6'd20}));
    tick();
    check("bp_rel_c1", 64'({out_valid, out_rob}), 64'({1'b1, 6'd21}));
    tick();
    check("bp_rel_c2", 64'({out_valid, out_rob}), 64'({1'b1, 6'd22}));
    tick();
    check("bp_rel_end", 64'({out_valid, count}), 64'd0);
    wait_drain(10);

    // fill to full with waiting operands; gaps in in_valid leave no holes
    begin
      int n;
      n = 0;
      for (int c = 0; c < 5; c++) begin
        for (int j = 0; j < NUM_IN; j++) begin
          if (!((c == 1 && (j == 1 || j == 3)) || (c == 3 && (j == 0 || j == 2)))) begin
            set_lane(j, 5'(n), 6'(32 + n), 6'd30, 1'b0, 16'h0000, 6'd0, 1'b1, 16'(n));
            push_exp(5'(n), 6'(32 + n), 16'h3030, 16'(n));
            n++;
          end
        end
        check("full_in_ready_pre", 64'(in_ready), 64'd1);
        tick();
        clear_inputs();
      end
      check("full_count16", 64'(count), 64'd16);
      check("full_in_ready0", 64'(in_ready), 64'd0);
      for (int j = 0; j < NUM_IN; j++)
        set_lane(j, 5'd31, 6'd63, 6'd0, 1'b1, 16'hDEAD, 6'd0, 1'b1, 16'hDEAD);
      tick();
      clear_inputs();
      check("full_reject_count", 64'(count), 64'd16);
      set_fwd(0, 6'd30, 16'h3030);
      tick();
      clear_inputs();
      wait_drain(40);
      check("full_drained", 64'(count), 64'd0);
    end

    // flush beats insert and issue
    set_lane(0, 5'd1, 6'd50, 6'd0, 1'b1, 16'h5050, 6'd0, 1'b1, 16'h5151);
    set_lane(1, 5'd1, 6'd51, 6'd0, 1'b1, 16'h5252, 6'd0, 1'b1, 16'h5353);
    tick();
    clear_inputs();
    check("fl_count2", 64'(count), 64'd2);
    flush = 1'b1;
    set_lane(0, 5'd1, 6'd52, 6'd0, 1'b1, 16'h0001, 6'd0, 1'b1, 16'h0002);
    tick();
    clear_inputs();
    check("fl_count0", 64'(count), 64'd0);
    check("fl_outv0", 64'(out_valid), 64'd0);
    tick();
    tick();
    check("fl_stay_empty", 64'({out_valid, count}), 64'd0);

    // reset mid-fill with an issued instruction held
    out_accept = 1'b0;
    for (int j = 0; j < 4; j++)
      set_lane(j, 5'(9 + j), 6'(60 + j), 6'd0, 1'b1, 16'(16'h6000 + j), 6'd0, 1'b1, 16'h7777);
    tick();
    clear_inputs();
    tick();
    check("rm_pre_outv", 64'(out_valid), 64'd1);
    reset = 1'b1;
    flush = 1'b1;
    set_lane(0, 5'd1, 6'd1, 6'd0, 1'b1, 16'h0001, 6'd0, 1'b1, 16'h0001);
    tick();
    clear_inputs();
    reset      = 1'b0;
    out_accept = 1'b1;
    check("rm_count0", 64'(count), 64'd0);
    check("rm_in_ready", 64'(in_ready), 64'd1);
    check("rm_out_all0", 64'({out_valid, out_op, out_rob, out_val_a, out_val_b}), 64'd0);
    repeat (4) tick();
    check("rm_no_issue", 64'({out_valid, count}), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
